// File: rtl/ecc_serdes.sv
// Serial/parallel bridge for an ECC core: loads N_IN serial operand lanes into a
// parallel word and shifts N_OUT parallel results back out serially, MSB first.
// Optional macro ECC_SERDES_ABORT_EN adds input i_abort to cancel a frame being loaded.
module ecc_serdes #(
  parameter int unsigned MAX_BITS = 256,
  parameter int unsigned N_IN     = 6,
  parameter int unsigned N_OUT    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic                      i_mode,
  input  logic [N_IN-1:0]           i_din,
`ifdef ECC_SERDES_ABORT_EN
  input  logic                      i_abort,
`endif
  output logic                      o_in_valid,
  input  logic                      i_in_ready,
  output logic [N_IN*MAX_BITS-1:0]  o_in_data,
  output logic [1:0]                o_mode,
  input  logic                      i_res_valid,
  output logic                      o_res_ready,
  input  logic [N_OUT*MAX_BITS-1:0] i_res_data,
  output logic [N_OUT-1:0]          o_dout,
  output logic                      o_dout_valid
);

  localparam int unsigned IW = $clog2(MAX_BITS);

  typedef enum logic [1:0] {IN_IDLE, IN_MODE, IN_LOAD, IN_HOLD} in_state_t;
  typedef enum logic       {OUT_IDLE, OUT_SHIFT}                out_state_t;

  // Operand length minus one, clamped to MAX_BITS so it always fits an IW-bit counter.
  function automatic logic [IW-1:0] len_m1(input logic [1:0] m);
    int unsigned l;
    l = 32'd32 << m;
    if (l > MAX_BITS) l = MAX_BITS;
    return IW'(l - 32'd1);
  endfunction

  in_state_t             in_state;
  out_state_t            out_state;
  logic [IW-1:0]         in_cnt;
  logic [IW-1:0]         out_cnt;
  logic [IW-1:0]         out_len_m1;
  logic                  mode_msb;
  logic                  mode_phase;
  logic                  abort;
  logic [MAX_BITS-1:0]   in_lane  [N_IN];
  logic [MAX_BITS-1:0]   res_lane [N_OUT];
  logic [MAX_BITS-1:0]   res_in   [N_OUT];

`ifdef ECC_SERDES_ABORT_EN
  assign abort = i_abort;
`else
  assign abort = 1'b0;
`endif

  for (genvar g = 0; g < N_IN; g++) begin : g_in_pack
    assign o_in_data[g*MAX_BITS +: MAX_BITS] = in_lane[g];
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_res_unpack
    assign res_in[g] = i_res_data[g*MAX_BITS +: MAX_BITS];
  end

  assign out_len_m1  = len_m1(o_mode);
  assign o_res_ready = (out_state == OUT_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_state   <= IN_IDLE;
      in_cnt     <= '0;
      mode_msb   <= 1'b0;
      mode_phase <= 1'b0;
      o_mode     <= '0;
      o_in_valid <= 1'b0;
      for (int unsigned k = 0; k < N_IN; k++) in_lane[k] <= '0;
    end else begin
      case (in_state)
        IN_IDLE: begin
          if (i_start) begin
            in_state   <= IN_MODE;
            mode_phase <= 1'b0;
            for (int unsigned k = 0; k < N_IN; k++) in_lane[k] <= '0;
          end
        end
        IN_MODE: begin
          if (abort) begin
            in_state   <= IN_IDLE;
            mode_phase <= 1'b0;
            for (int unsigned k = 0; k < N_IN; k++) in_lane[k] <= '0;
          end else if (!mode_phase) begin
            mode_msb   <= i_mode;
            mode_phase <= 1'b1;
          end else begin
            o_mode     <= {mode_msb, i_mode};
            in_cnt     <= len_m1({mode_msb, i_mode});
            mode_phase <= 1'b0;
            in_state   <= IN_LOAD;
          end
        end
        IN_LOAD: begin
          if (abort) begin
            in_state <= IN_IDLE;
            for (int unsigned k = 0; k < N_IN; k++) in_lane[k] <= '0;
          end else begin
            for (int unsigned k = 0; k < N_IN; k++)
              in_lane[k] <= {in_lane[k][MAX_BITS-2:0], i_din[k]};
            if (in_cnt == '0) in_state <= IN_HOLD;
            else              in_cnt   <= in_cnt - IW'(1);
          end
        end
        IN_HOLD: begin
          // valid rises one cycle after entry; ready only counts once valid is visible
          if (!o_in_valid) begin
            o_in_valid <= 1'b1;
          end else if (i_in_ready) begin
            o_in_valid <= 1'b0;
            in_state   <= IN_IDLE;
          end
        end
        default: in_state <= IN_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_state    <= OUT_IDLE;
      out_cnt      <= '0;
      o_dout       <= '0;
      o_dout_valid <= 1'b0;
      for (int unsigned k = 0; k < N_OUT; k++) res_lane[k] <= '0;
    end else begin
      case (out_state)
        OUT_IDLE: begin
          if (i_res_valid) begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
              res_lane[k] <= res_in[k];
              o_dout[k]   <= res_in[k][out_len_m1];
            end
            out_cnt      <= out_len_m1;
            o_dout_valid <= 1'b1;
            out_state    <= OUT_SHIFT;
          end
        end
        OUT_SHIFT: begin
          // out_cnt indexes the bit currently on o_dout; the next one is out_cnt-1
          if (out_cnt == '0) begin
            o_dout       <= '0;
            o_dout_valid <= 1'b0;
            out_state    <= OUT_IDLE;
          end else begin
            for (int unsigned k = 0; k < N_OUT; k++)
              o_dout[k] <= res_lane[k][out_cnt - IW'(1)];
            out_cnt <= out_cnt - IW'(1);
          end
        end
        default: out_state <= OUT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_serdes.sv
// Directed, table-driven bench for ecc_serdes at default parameters.
// Define ECC_SERDES_ABORT_EN for both files to exercise the abort path.
module tb_ecc_serdes;
  localparam int unsigned MB = 256;
  localparam int unsigned NI = 6;
  localparam int unsigned NO = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_start = 1'b0;
  logic              i_mode = 1'b0;
  logic [NI-1:0]     i_din = '0;
`ifdef ECC_SERDES_ABORT_EN
  logic              i_abort = 1'b0;
`endif
  logic              o_in_valid;
  logic              i_in_ready = 1'b1;
  logic [NI*MB-1:0]  o_in_data;
  logic [1:0]        o_mode;
  logic              i_res_valid = 1'b0;
  logic              o_res_ready;
  logic [NO*MB-1:0]  i_res_data = '0;
  logic [NO-1:0]     o_dout;
  logic              o_dout_valid;

  int unsigned checks = 0;
  int unsigned failures = 0;

  ecc_serdes #(.MAX_BITS(MB), .N_IN(NI), .N_OUT(NO)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_mode(i_mode), .i_din(i_din),
`ifdef ECC_SERDES_ABORT_EN
    .i_abort(i_abort),
`endif
    .o_in_valid(o_in_valid), .i_in_ready(i_in_ready), .o_in_data(o_in_data),
    .o_mode(o_mode), .i_res_valid(i_res_valid), .o_res_ready(o_res_ready),
    .i_res_data(i_res_data), .o_dout(o_dout), .o_dout_valid(o_dout_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   mode;
    int unsigned  len;
    logic [255:0] din_a;
    logic [255:0] din_b;
    int unsigned  exp_cyc;
    logic [255:0] exp_a;
    logic [255:0] exp_b;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] lane(input int unsigned k);
    return o_in_data[k*MB +: MB];
  endfunction

  // Sends one input frame starting in the current cycle (cycle 0 = i_start high).
  task automatic frame(input logic [1:0] m, input logic [255:0] a, input logic [255:0] b,
                       input int unsigned len, input int extra_start_at, input int res_at,
                       input int rst_at, input int abort_at);
    i_start = 1'b1; tick();
    i_start = 1'b0; i_mode = m[1]; tick();
    i_mode = m[0]; tick();
    i_mode = 1'b0;
    for (int unsigned bi = 0; bi < len; bi++) begin
      i_din[0] = a[len-1-bi];
      for (int unsigned k = 1; k < NI; k++) i_din[k] = b[len-1-bi];
      i_start     = (int'(bi) == extra_start_at);
      i_res_valid = (int'(bi) == res_at);
      if (int'(bi) == rst_at) begin
        rst = 1'b0; tick(); rst = 1'b1;
        i_din = '0; i_start = 1'b0; i_res_valid = 1'b0;
        return;
      end
      if (int'(bi) == abort_at) begin
`ifdef ECC_SERDES_ABORT_EN
        i_abort = 1'b1;
`endif
        tick();
`ifdef ECC_SERDES_ABORT_EN
        i_abort = 1'b0;
`endif
        i_din = '0; i_start = 1'b0; i_res_valid = 1'b0;
        return;
      end
      tick();
    end
    i_din = '0; i_start = 1'b0; i_res_valid = 1'b0;
  endtask

  // Waits (bounded) for o_in_valid after a full frame; returns the cycle it was seen.
  task automatic wait_valid(input int unsigned len, output int unsigned cyc);
    cyc = len + 3;
    while (!o_in_valid && cyc < len + 40) begin tick(); cyc++; end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int unsigned cyc;
    i_in_ready = 1'b1;
    frame(v.mode, v.din_a, v.din_b, v.len, -1, -1, -1, -1);
    wait_valid(v.len, cyc);
    check({tag, "_valid_cycle"}, 256'(cyc), 256'(v.exp_cyc));
    check({tag, "_lane0"}, lane(0), v.exp_a);
    check({tag, "_lane5"}, lane(5), v.exp_b);
    check({tag, "_mode"}, 256'(o_mode), 256'(v.mode));
    tick();
    check({tag, "_valid_drop"}, 256'(o_in_valid), 256'(0));
  endtask

  // Captures n serial result cycles once o_dout_valid rises (bounded wait).
  task automatic collect(input int unsigned n, output logic [255:0] l0, output logic [255:0] l1,
                         output int unsigned nvalid, output int unsigned nbusy);
    int unsigned w = 0;
    l0 = '0; l1 = '0; nvalid = 0; nbusy = 0;
    while (!o_dout_valid && w < 300) begin tick(); w++; end
    for (int unsigned i = 0; i < n; i++) begin
      if (o_dout_valid) nvalid++;
      if (!o_res_ready) nbusy++;
      l0 = {l0[254:0], o_dout[0]};
      l1 = {l1[254:0], o_dout[1]};
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] l0, l1;
    int unsigned  nv, nb, cyc, seen;

    vecs[0] = '{2'b00, 32,  {{224{1'b1}}, 32'h8000_0001}, 256'hFFFF_FFFF, 36,
                256'h8000_0001, 256'hFFFF_FFFF};
    vecs[1] = '{2'b01, 64,  {{192{1'b1}}, 64'hA5A5_0000_FFFF_0001}, 256'h0123_4567_89AB_CDEF, 68,
                256'hA5A5_0000_FFFF_0001, 256'h0123_4567_89AB_CDEF};
    vecs[2] = '{2'b10, 128, {128'hFFFF, 128'h8000_0000_0000_0000_0000_0000_0000_0003},
                256'hDEAD_BEEF_0000_0000_1111_2222_3333_4444, 132,
                256'h8000_0000_0000_0000_0000_0000_0000_0003,
                256'hDEAD_BEEF_0000_0000_1111_2222_3333_4444};
    vecs[3] = '{2'b11, 256, 256'h1, {128'hC000_0000_0000_0000_0000_0000_0000_0000, 128'h5}, 260,
                256'h1, {128'hC000_0000_0000_0000_0000_0000_0000_0000, 128'h5}};

    // reset state
    tick(); tick();
    check("rst_in_valid", 256'(o_in_valid), 256'(0));
    check("rst_dout_valid", 256'(o_dout_valid), 256'(0));
    check("rst_dout", 256'(o_dout), 256'(0));
    check("rst_mode", 256'(o_mode), 256'(0));
    check("rst_lane0", lane(0), 256'(0));
    rst = 1'b1;
    tick();
    check("rst_res_ready", 256'(o_res_ready), 256'(1));

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // core back-pressure: operands must hold until ready
    i_in_ready = 1'b0;
    frame(2'b11, '1, '1, 256, -1, -1, -1, -1);
    wait_valid(256, cyc);
    check("hold_valid_cycle", 256'(cyc), 256'(260));
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 256'(o_in_valid), 256'(1));
      tick();
    end
    check("hold_lane0", lane(0), '1);
    check("hold_lane5", lane(5), '1);
    check("hold_valid_last", 256'(o_in_valid), 256'(1));
    i_in_ready = 1'b1;
    tick();
    check("hold_drop", 256'(o_in_valid), 256'(0));

    // result shift with o_mode=01
    run_vec(vecs[1], "pre_out");
    check("out_ready_idle", 256'(o_res_ready), 256'(1));
    check("out_dout_idle", 256'(o_dout), 256'(0));
    i_res_data = {256'h8000_0000_0000_0000, {192{1'b1}}, 64'h1};
    i_res_valid = 1'b1; tick(); i_res_valid = 1'b0;
    collect(64, l0, l1, nv, nb);
    check("out64_nvalid", 256'(nv), 256'(64));
    check("out64_busy", 256'(nb), 256'(64));
    check("out64_lane0", l0, 256'h1);
    check("out64_lane1", l1, 256'h8000_0000_0000_0000);
    check("out64_end_valid", 256'(o_dout_valid), 256'(0));
    check("out64_end_dout", 256'(o_dout), 256'(0));
    check("out64_end_ready", 256'(o_res_ready), 256'(1));

    // stray start during load, output shift overlapping the frame
    i_in_ready = 1'b0;
    i_res_data = {256'h1234_5678, {224{1'b1}}, 32'hCAFE_BABE};
    fork
      begin
        frame(2'b00, 256'h0F0F_1234, 256'h5555_AAAA, 32, 10, 5, -1, -1);
        wait_valid(32, cyc);
      end
      collect(32, l0, l1, nv, nb);
    join
    check("ovl_valid_cycle", 256'(cyc), 256'(36));
    check("ovl_in_valid", 256'(o_in_valid), 256'(1));
    check("ovl_lane0", lane(0), 256'h0F0F_1234);
    check("ovl_lane5", lane(5), 256'h5555_AAAA);
    check("ovl_nvalid", 256'(nv), 256'(32));
    check("ovl_out_lane0", l0, 256'hCAFE_BABE);
    check("ovl_out_lane1", l1, 256'h1234_5678);
    check("ovl_out_end", 256'(o_dout_valid), 256'(0));
    i_in_ready = 1'b1;
    tick();
    check("ovl_drop", 256'(o_in_valid), 256'(0));

    // reset at data bit 20 of a mode-10 frame with a 128-bit shift in flight
    i_res_data = {256'h0, {256{1'b1}}};
    frame(2'b10, '1, '1, 128, -1, 5, 20, -1);
    check("mrst_in_valid", 256'(o_in_valid), 256'(0));
    check("mrst_dout_valid", 256'(o_dout_valid), 256'(0));
    check("mrst_dout", 256'(o_dout), 256'(0));
    check("mrst_mode", 256'(o_mode), 256'(0));
    check("mrst_lane0", lane(0), 256'(0));
    check("mrst_res_ready", 256'(o_res_ready), 256'(1));
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      if (o_in_valid || o_dout_valid) seen++;
      tick();
    end
    check("mrst_no_output", 256'(seen), 256'(0));
    run_vec(vecs[0], "post_rst");

`ifdef ECC_SERDES_ABORT_EN
    frame(2'b00, 256'h8000_0001, 256'hFFFF_FFFF, 32, -1, -1, -1, 5);
    check("abort_lane0", lane(0), 256'(0));
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (o_in_valid) seen++;
      tick();
    end
    check("abort_no_valid", 256'(seen), 256'(0));
    run_vec(vecs[0], "post_abort");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ecc_serdes.md
ECC_SERDES -- requirements
Module: ecc_serdes

Interface
REQ-001 SHALL have parameter MAX_BITS, default 256: widest operand in bits; legal values 32, 64, 128, 256.
REQ-002 SHALL have parameter N_IN, default 6: number of serial input operand lanes.
REQ-003 SHALL have parameter N_OUT, default 2: number of serial result lanes.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_start  input  1  one-cycle pulse that opens an input frame.
REQ-007 SHALL have port i_mode  input  1  serial mode bits, MSB first.
REQ-008 SHALL have port i_din  input  N_IN  one serial data bit per lane, MSB first.
REQ-009 SHALL have port o_in_valid  output  1  parallel operands valid toward the core.
REQ-010 SHALL have port i_in_ready  input  1  core accepts the operands.
REQ-011 SHALL have port o_in_data  output  N_IN*MAX_BITS  operands; lane k occupies bits [k*MAX_BITS +: MAX_BITS].
REQ-012 SHALL have port o_mode  output  2  mode of the current or last frame.
REQ-013 SHALL have port i_res_valid  input  1  core result valid.
REQ-014 SHALL have port o_res_ready  output  1  result accepted.
REQ-015 SHALL have port i_res_data  input  N_OUT*MAX_BITS  parallel results, packed in the same way as o_in_data.
REQ-016 SHALL have port o_dout  output  N_OUT  serial result bits, MSB first.
REQ-017 SHALL have port o_dout_valid  output  1  o_dout carries a valid bit.

Function
REQ-018 Operand length L: mode 00=32, 01=64, 10=128, 11=256; a mode with L > MAX_BITS SHALL be clamped to MAX_BITS.
REQ-019 Input FSM states SHALL be IN_IDLE, IN_MODE, IN_LOAD, IN_HOLD.
REQ-020 IN_IDLE: on i_start=1, go to IN_MODE and clear all operand registers to 0.
REQ-021 IN_MODE: capture i_mode during the 2 cycles after i_start, MSB first, then go to IN_LOAD.
REQ-022 IN_LOAD: shift i_din into each lane LSB-side for exactly L cycles; the first data bit arrives on cycle 3 after i_start; upper MAX_BITS-L bits stay 0.
REQ-023 After the last data bit, the input FSM SHALL enter IN_HOLD with o_in_valid=1 on the next cycle.
REQ-024 IN_HOLD: keep o_in_valid and o_in_data stable until i_in_ready=1 is sampled, then return to IN_IDLE with o_in_valid=0 on the following cycle.
REQ-025 i_start SHALL be ignored in every state except IN_IDLE.
REQ-026 o_mode SHALL update when the second mode bit is captured and hold until the next frame's mode capture.
REQ-027 The output engine SHALL operate independently of the input FSM, with states OUT_IDLE and OUT_SHIFT.
REQ-028 o_res_ready SHALL be combinational and equal to 1 exactly when the output engine is in OUT_IDLE.
REQ-029 A result SHALL be accepted when i_res_valid=1 and o_res_ready=1; on acceptance, latch i_res_data and latch Lout = L(o_mode).
REQ-030 OUT_SHIFT SHALL begin the cycle after acceptance and last exactly Lout cycles, driving o_dout_valid=1 and bit Lout-1 first, down to bit 0.
REQ-031 On OUT_SHIFT exit, o_dout_valid SHALL drop to 0 and the engine SHALL return to OUT_IDLE; back-to-back results therefore have a one-cycle gap.
REQ-032 o_dout SHALL be 0 whenever o_dout_valid=0.
REQ-033 Input loading and output shifting SHALL run concurrently without interfering with each other.

Reset
REQ-034 rst=0 at a clock edge SHALL force IN_IDLE and OUT_IDLE, clear all operand, mode, result and counter registers, and drive o_in_valid=0, o_dout_valid=0, o_dout=0, o_mode=00.
REQ-035 Reset asserted mid-frame or mid-shift SHALL discard the partial frame or result; no output SHALL be produced for it after reset release.
REQ-036 o_res_ready SHALL read 1 from the first cycle after reset release.

Configuration
REQ-037 Macro ECC_SERDES_ABORT_EN defined: add port i_abort (input, 1); i_abort=1 in IN_MODE or IN_LOAD SHALL return the input FSM to IN_IDLE and zero the operands; i_abort SHALL be ignored in IN_IDLE and IN_HOLD and SHALL have no effect on the output engine.
REQ-038 Macro ECC_SERDES_ABORT_EN undefined: port i_abort SHALL be absent and frames SHALL always run to completion.

Verification
REQ-039 Test: mode=00, lane0 serial 0x8000_0001, i_in_ready held 1 -> o_in_valid high on cycle 36 after i_start, lane0=0x...0080000001 zero-extended, o_mode=00.
REQ-040 Test: mode=11, all lanes 0xFF..F, i_in_ready=0 for 10 cycles -> o_in_valid and data stable for all 10 cycles, then 1 cycle after ready it drops.
REQ-041 Test: o_mode=01, i_res_data lane0=0x1, lane1=0x8000_0000_0000_0000 -> 64 valid cycles; lane0 shows 63 zeros then 1; lane1 shows 1 then 63 zeros.
REQ-042 Test: i_start pulsed during IN_LOAD, plus an output shift overlapping the frame -> second start ignored, both transfers correct.
REQ-043 Test: rst=0 at data bit 20 of a mode-10 frame -> all outputs 0 the next cycle; a following clean mode-00 frame completes correctly.
REQ-044 Test (ABORT_EN): i_abort at bit 5 -> back to IN_IDLE, o_in_valid never asserts; the next frame is correct.
